bicubic_tap_scheduler: RTL and testbench

- Time-multiplexes one shared, fixed-latency bicubic kernel-weight evaluator across the 8 tap distances of one output pixel: 4 horizontal taps, then 4 vertical taps.
- Accepts fractional phases fx/fy and the kernel parameter a from the scaler address generator.
- Issues one distance per cycle, collects the in-order results, and presents both weight vectors with a valid/ready handshake.
- Sits between the scaler coordinate stage and the 4x4 filter MAC.

---
 rtl/bicubic_tap_scheduler_if.sv | 28 ++
 rtl/bicubic_tap_scheduler.sv | 129 ++++++++++++
 tb/tb_bicubic_tap_scheduler.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bicubic_tap_scheduler_if.sv
// rtl/bicubic_tap_scheduler_if.sv - request, evaluator and weight-output signals of the tap scheduler
interface bicubic_tap_scheduler_if #(
   parameter int WW = 17
);
   logic            req_valid;
   logic            req_ready;
   logic [8:0]      req_fx;
   logic [8:0]      req_fy;
   logic [8:0]      req_a;
   logic            eval_valid;
   logic [9:0]      eval_d;
   logic [8:0]      eval_a;
   logic [WW-1:0]   eval_res;
   logic            out_valid;
   logic            out_ready;
   logic [4*WW-1:0] out_wx;
   logic [4*WW-1:0] out_wy;

   modport slave (
      input  req_valid, req_fx, req_fy, req_a, eval_res, out_ready,
      output req_ready, eval_valid, eval_d, eval_a, out_valid, out_wx, out_wy
   );

   modport master (
      output req_valid, req_fx, req_fy, req_a, eval_res, out_ready,
      input  req_ready, eval_valid, eval_d, eval_a, out_valid, out_wx, out_wy
   );
endinterface

// File: rtl/bicubic_tap_scheduler.sv
// rtl/bicubic_tap_scheduler.sv - issues 8 bicubic tap distances to a shared evaluator
// and gathers the in-order results into horizontal/vertical weight vectors
module bicubic_tap_scheduler #(
   parameter int LAT = 4,
   parameter int WW  = 17
) (
   input  logic                   clk,
   input  logic                   rst_n,
   bicubic_tap_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

   state_e               state_q;
   logic [2:0]           idx_q;
   logic [8:0]           fx_q, fy_q, a_q;
   logic                 eval_valid_q;
   logic [9:0]           eval_d_q;
   logic [8:0]           eval_a_q;
   logic                 out_valid_q;
   logic [3:0][WW-1:0]   wx_q, wy_q;
   logic [LAT-1:0]       trk_vld_q;
   logic [LAT-1:0][2:0]  trk_idx_q;

   logic                 req_ready;
   logic                 accept;
   logic [8:0]           fx_sat, fy_sat;
   logic [2:0]           nxt_idx;
   logic [9:0]           nxt_dist;
   logic                 cap_vld;
   logic [2:0]           cap_idx;

   function automatic logic [9:0] tap_dist(input logic [1:0] k, input logic [8:0] f);
      logic [9:0] fe;
      fe = {1'b0, f};
      case (k)
         2'd0:    return 10'd256 + fe;
         2'd1:    return fe;
         2'd2:    return 10'd256 - fe;
         default: return 10'd512 - fe;
      endcase
   endfunction

   always_comb begin
      req_ready = (state_q == IDLE) || ((state_q == OUT) && bus.out_ready);
      accept    = bus.req_valid && req_ready;
      fx_sat    = (bus.req_fx > 9'd256) ? 9'd256 : bus.req_fx;
      fy_sat    = (bus.req_fy > 9'd256) ? 9'd256 : bus.req_fy;
      nxt_idx   = idx_q + 3'd1;
      nxt_dist  = tap_dist(nxt_idx[1:0], nxt_idx[2] ? fy_q : fx_q);
      cap_vld   = trk_vld_q[LAT-1];
      cap_idx   = trk_idx_q[LAT-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= 3'd0;
         fx_q         <= 9'd0;
         fy_q         <= 9'd0;
         a_q          <= 9'd0;
         eval_valid_q <= 1'b0;
         eval_d_q     <= 10'd0;
         eval_a_q     <= 9'd0;
         out_valid_q  <= 1'b0;
         wx_q         <= '0;
         wy_q         <= '0;
         trk_vld_q    <= '0;
         trk_idx_q    <= '0;
      end else begin
         // Each evaluator result is matched to its issue by delaying {valid, idx} by LAT.
         for (int i = LAT - 1; i > 0; i--) begin
            trk_vld_q[i] <= trk_vld_q[i-1];
            trk_idx_q[i] <= trk_idx_q[i-1];
         end
         trk_vld_q[0] <= eval_valid_q;
         trk_idx_q[0] <= idx_q;

         if (cap_vld) begin
            if (!cap_idx[2]) wx_q[cap_idx[1:0]] <= bus.eval_res;
            else             wy_q[cap_idx[1:0]] <= bus.eval_res;
         end

         case (state_q)
            IDLE, OUT: begin
               if ((state_q == OUT) && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
               // Issue of tap 0 is launched directly from the accept cycle.
               if (accept) begin
                  fx_q         <= fx_sat;
                  fy_q         <= fy_sat;
                  a_q          <= bus.req_a;
                  idx_q        <= 3'd0;
                  eval_valid_q <= 1'b1;
                  eval_d_q     <= tap_dist(2'd0, fx_sat);
                  eval_a_q     <= bus.req_a;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               if (idx_q == 3'd7) begin
                  eval_valid_q <= 1'b0;
                  state_q      <= DRAIN;
               end else begin
                  idx_q    <= nxt_idx;
                  eval_d_q <= nxt_dist;
                  eval_a_q <= a_q;
               end
            end
            DRAIN: begin
               if (cap_vld && (cap_idx == 3'd7)) begin
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.eval_valid = eval_valid_q;
   assign bus.eval_d     = eval_d_q;
   assign bus.eval_a     = eval_a_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_wx     = wx_q;
   assign bus.out_wy     = wy_q;
endmodule

// File: tb/tb_bicubic_tap_scheduler.sv
// tb/tb_bicubic_tap_scheduler.sv - scoreboard bench for bicubic_tap_scheduler
module tb_bicubic_tap_scheduler;
   localparam int LAT = 4;
   localparam int WW  = 17;
   localparam int PIX = 9 + LAT;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_hs = -1;
   logic ov_prev = 1'b0;

   typedef struct {
      logic [4*WW-1:0] wx;
      logic [4*WW-1:0] wy;
      int              cyc;
   } out_exp_t;

   typedef struct {
      logic [9:0] d;
      logic [8:0] a;
      int         cyc;
   } ev_exp_t;

   out_exp_t exp_out[$];
   ev_exp_t  exp_ev[$];

   bicubic_tap_scheduler_if #(.WW(WW)) bus ();

   bicubic_tap_scheduler #(.LAT(LAT), .WW(WW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Evaluator stub: returns the zero-extended distance exactly LAT cycles later.
   logic [9:0] pipe [LAT];
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= bus.eval_d;
   end
   assign bus.eval_res = {{(WW-10){1'b0}}, pipe[LAT-1]};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [39:0] dv(input logic [9:0] d0, input logic [9:0] d1,
                                      input logic [9:0] d2, input logic [9:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic logic [4*WW-1:0] pack_w(input logic [39:0] d);
      logic [4*WW-1:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) w[k*WW +: WW] = {{(WW-10){1'b0}}, d[k*10 +: 10]};
      return w;
   endfunction

   // Monitor: pops scoreboard entries when the DUT issues or presents weights.
   always @(negedge clk) begin
      ev_exp_t  e;
      out_exp_t o;
      if (rst_n && bus.eval_valid) begin
         if (exp_ev.size() == 0) begin
            chk("eval_unexpected", 1'b1, 1'b0);
         end else begin
            e = exp_ev.pop_front();
            chk("eval_d", bus.eval_d, e.d);
            chk("eval_a", bus.eval_a, e.a);
            chk("eval_cycle", cyc, e.cyc);
         end
      end
      if (rst_n && bus.out_valid && !ov_prev) begin
         if (exp_out.size() == 0) begin
            chk("out_unexpected", 1'b1, 1'b0);
         end else begin
            o = exp_out.pop_front();
            chk("out_wx", bus.out_wx, o.wx);
            chk("out_wy", bus.out_wy, o.wy);
            chk("out_cycle", cyc, o.cyc);
         end
      end
      if (bus.out_valid && bus.out_ready) last_hs = cyc;
      ov_prev = bus.out_valid;
   end

   task automatic send(input logic [8:0] fx, input logic [8:0] fy, input logic [8:0] a,
                       input logic [39:0] dx, input logic [39:0] dy, output int t_acc);
      bit       ok;
      ev_exp_t  e;
      out_exp_t o;
      ok = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_fx    = fx;
      bus.req_fy    = fy;
      bus.req_a     = a;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1'b1;
      end
      t_acc = cyc;
      chk("accept_timeout", ok, 1'b1);
      if (ok) begin
         for (int i = 0; i < 8; i++) begin
            e.d   = (i < 4) ? dx[i*10 +: 10] : dy[(i-4)*10 +: 10];
            e.a   = a;
            e.cyc = t_acc + 1 + i;
            exp_ev.push_back(e);
         end
         o.wx  = pack_w(dx);
         o.wy  = pack_w(dy);
         o.cyc = t_acc + PIX;
         exp_out.push_back(o);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_fx    = 9'h1AA;
      bus.req_fy    = 9'h0F3;
      bus.req_a     = 9'h155;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (exp_out.size() == 0 && exp_ev.size() == 0) done = 1'b1;
      end
      chk("drain_timeout", done, 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
      chk({tag, "_eval_valid"}, bus.eval_valid, 1'b0);
      chk({tag, "_eval_d"}, bus.eval_d, 10'd0);
      chk({tag, "_eval_a"}, bus.eval_a, 9'd0);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_out_wx"}, bus.out_wx, '0);
      chk({tag, "_out_wy"}, bus.out_wy, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2, t3, tb_acc;
      logic [39:0] ax, ay;
      bus.req_valid = 1'b0;
      bus.req_fx    = 9'd0;
      bus.req_fy    = 9'd0;
      bus.req_a     = 9'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single request
      send(9'd0, 9'd128, 9'd128, dv(256, 0, 256, 512), dv(384, 128, 128, 384), t1);
      wait_idle();

      // Phase saturation
      send(9'd300, 9'd0, 9'd511, dv(512, 256, 0, 256), dv(256, 0, 256, 512), t1);
      wait_idle();

      // Backpressure, then accept in the handshake cycle
      bus.out_ready = 1'b0;
      ax = dv(512, 256, 0, 256);
      ay = dv(288, 32, 224, 480);
      send(9'd256, 9'd32, 9'd5, ax, ay, t1);
      for (int i = 0; i < 300 && !bus.out_valid; i++) @(negedge clk);
      chk("bp_present", bus.out_valid, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_out_valid", bus.out_valid, 1'b1);
         chk("bp_wx", bus.out_wx, pack_w(ax));
         chk("bp_wy", bus.out_wy, pack_w(ay));
         chk("bp_req_ready", bus.req_ready, 1'b0);
         chk("bp_eval_valid", bus.eval_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(9'd100, 9'd200, 9'd77, dv(356, 100, 156, 412), dv(456, 200, 56, 312), tb_acc);
      chk("bp_accept_on_handshake", tb_acc, last_hs);
      wait_idle();

      // Back-to-back
      send(9'd1, 9'd255, 9'd1, dv(257, 1, 255, 511), dv(511, 255, 1, 257), t1);
      send(9'd128, 9'd64, 9'd256, dv(384, 128, 128, 384), dv(320, 64, 192, 448), t2);
      send(9'd511, 9'd257, 9'd0, dv(512, 256, 0, 256), dv(512, 256, 0, 256), t3);
      chk("b2b_spacing_1", t2 - t1, PIX);
      chk("b2b_spacing_2", t3 - t2, PIX);
      wait_idle();

      // Reset during DRAIN aborts the request
      send(9'd16, 9'd16, 9'd9, dv(272, 16, 240, 496), dv(272, 16, 240, 496), t1);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_out.delete(exp_out.size() - 1);
      @(posedge clk);
      @(negedge clk);
      chk_zero("midrst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(9'd64, 9'd0, 9'd200, dv(320, 64, 192, 448), dv(256, 0, 256, 512), t1);
      wait_idle();
      repeat (LAT + 4) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
